om_max_buffer: RTL and testbench
================================

OM_MAX_BUFFER -- requirements
Module: om_max_buffer

Interface
REQ-001 Parameter MAP_W, default 81: output-map row width in entries.
REQ-002 Parameter MAP_N, default 6561: entries per frame (MAP_W x 81); MAP_N SHALL be <= 8191.
REQ-003 iClk  input  1  clock, all logic on rising edge.
REQ-004 iReset_n  input  1  reset, synchronous, active-low.
REQ-005 iFinish  input  1  synchronous frame abort/clear, same effect as reset except RAM contents.
REQ-006 iScore_valid  input  1  iScore valid this cycle.
REQ-007 iScore  input  32  unsigned correlation score, raster order.
REQ-008 oScore_ready  output  1  block accepts scores; transfer = iScore_valid & oScore_ready.
REQ-009 oInput_ready  output  1  one-cycle pulse: frame complete, oPosition/oMax_val valid.
REQ-010 oPosition  output  13  address of maximum score.
REQ-011 oMax_val  output  32  maximum score of frame.
REQ-012 iAddr_OM  input  13  read address from consumer.
REQ-013 oData_from_OM  output  32  read data, registered.
REQ-014 iResult_done  input  1  consumer finished with result (consumer's output-ready or end pulse).

Function
REQ-015 Internal RAM SHALL hold MAP_N x 32-bit words; write port driven by accepted scores, read port by iAddr_OM.
REQ-016 States: IDLE, FILL, DONE, WAIT.
REQ-017 IDLE: oScore_ready=1; first transfer writes address 0, loads max=iScore, maxpos=0, wcnt=1, -> FILL.
REQ-018 FILL: oScore_ready=1; each transfer writes address wcnt; if iScore > max (strict) max<=iScore, maxpos<=wcnt; wcnt increments.
REQ-019 Ties SHALL keep the earliest position.
REQ-020 Transfer at wcnt=MAP_N-1 SHALL complete the frame -> DONE next cycle; oScore_ready=0 from that next cycle.
REQ-021 DONE: oInput_ready=1 for exactly one cycle with oPosition=maxpos, oMax_val=max, -> WAIT.
REQ-022 WAIT: oScore_ready=0, oPosition/oMax_val held; iResult_done=1 -> IDLE next cycle, wcnt<=0.
REQ-023 iResult_done outside WAIT SHALL be ignored.
REQ-024 Read latency SHALL be exactly 1 cycle: iAddr_OM sampled at edge N, oData_from_OM valid after edge N+1... i.e. data present for the cycle following the address cycle; reads legal in every state.
REQ-025 Reading the address being written in the same cycle SHALL return the old contents.
REQ-026 iScore_valid with oScore_ready=0 SHALL not write and not update max.
REQ-027 Gaps in iScore_valid SHALL not affect result.

Reset
REQ-028 On iReset_n=0 or iFinish=1: state=IDLE, wcnt=0, max=0, maxpos=0, oInput_ready=0, oPosition=0, oMax_val=0, oData_from_OM=0, oScore_ready=1 next cycle; RAM not cleared.
REQ-029 Reset/iFinish mid-FILL or in WAIT SHALL abandon the frame; no oInput_ready issued.
REQ-030 Reset SHALL take priority over every simultaneous event.

Configuration
REQ-031 Macro OM_ADDR_GUARD_EN defined: iAddr_OM >= MAP_N returns oData_from_OM=0 (consumer reads past map end, e.g. maxpos+162+1).
REQ-032 OM_ADDR_GUARD_EN undefined: out-of-range address returns unspecified data, no range logic synthesized.

Verification
REQ-033 Ramp 0..6560 scores, max at 6560 -> oInput_ready pulse 1 cycle, oPosition=6560, oMax_val=6560.
REQ-034 All scores 5 except 0x4E66667 at addresses 100 and 200 -> oPosition=100.
REQ-035 After frame, iAddr_OM=262 -> oData_from_OM equals score written at 262 one cycle later; with guard, iAddr_OM=6600 -> 0.
REQ-036 iScore_valid during WAIT with value 0xFFFFFFFF -> oMax_val unchanged, oScore_ready=0; iResult_done -> IDLE, next frame accepted.
REQ-037 iFinish at wcnt=3000 -> no oInput_ready, outputs 0, new full frame yields correct max.
REQ-038 Random iScore_valid gaps (50% duty) -> identical result to gapless stream.

Source files
------------

// File: rtl/om_max_buffer_if.sv
// Score stream handshake between the correlator (master) and om_max_buffer (slave).
interface om_max_buffer_if;
    logic        score_valid;
    logic [31:0] score;
    logic        score_ready;

    modport master (output score_valid, output score, input score_ready);
    modport slave  (input score_valid, input score, output score_ready);
endinterface

// File: rtl/om_max_buffer.sv
// Buffers one frame of correlation scores into RAM, tracks the (earliest) maximum and its address.
// Define OM_ADDR_GUARD_EN to force reads at addresses >= MAP_N to return zero.
module om_max_buffer #(
    parameter int unsigned MAP_W = 81,
    parameter int unsigned MAP_N = 6561
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iFinish,
    om_max_buffer_if.slave        score_if,
    output logic                  oInput_ready,
    output logic [12:0]           oPosition,
    output logic [31:0]           oMax_val,
    input  logic [12:0]           iAddr_OM,
    output logic [31:0]           oData_from_OM,
    input  logic                  iResult_done
);

    if (MAP_N == 0 || MAP_N > 8191 || MAP_W == 0) begin : g_param_check
        $error("om_max_buffer: MAP_N must be 1..8191 and MAP_W nonzero");
    end

    typedef enum logic [1:0] {StIdle, StFill, StDone, StWait} state_e;

    state_e      state_q;
    logic [12:0] wcnt_q;
    logic [12:0] max_pos_q;
    logic [31:0] max_val_q;
    logic        score_ready_q;
    logic [31:0] ram [MAP_N];

    logic clear;
    logic xfer;
    logic take;
    logic last;

    assign clear = ~iReset_n | iFinish;
    assign xfer  = score_if.score_valid & score_ready_q;
    // First score of a frame always seeds the maximum; afterwards only a strictly larger one wins.
    assign take  = (state_q == StIdle) || (score_if.score > max_val_q);
    assign last  = (wcnt_q == 13'(MAP_N - 1));

    assign score_if.score_ready = score_ready_q;

    always_ff @(posedge iClk) begin
        if (clear) begin
            state_q       <= StIdle;
            wcnt_q        <= '0;
            max_pos_q     <= '0;
            max_val_q     <= '0;
            score_ready_q <= 1'b1;
            oInput_ready  <= 1'b0;
            oPosition     <= '0;
            oMax_val      <= '0;
        end else begin
            oInput_ready <= 1'b0;
            case (state_q)
                StIdle, StFill: begin
                    if (xfer) begin
                        if (take) begin
                            max_val_q <= score_if.score;
                            max_pos_q <= wcnt_q;
                        end
                        if (last) begin
                            state_q       <= StDone;
                            score_ready_q <= 1'b0;
                            oInput_ready  <= 1'b1;
                            oPosition     <= take ? wcnt_q : max_pos_q;
                            oMax_val      <= take ? score_if.score : max_val_q;
                        end else begin
                            state_q <= StFill;
                            wcnt_q  <= wcnt_q + 13'd1;
                        end
                    end
                end
                StDone: state_q <= StWait;
                StWait: begin
                    if (iResult_done) begin
                        state_q       <= StIdle;
                        wcnt_q        <= '0;
                        score_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM contents survive reset; only the write is suppressed while clearing.
    always_ff @(posedge iClk) begin
        if (xfer && !clear) begin
            ram[wcnt_q] <= score_if.score;
        end
    end

    always_ff @(posedge iClk) begin
        if (clear) begin
            oData_from_OM <= '0;
        end else begin
`ifdef OM_ADDR_GUARD_EN
            if (iAddr_OM >= 13'(MAP_N)) begin
                oData_from_OM <= '0;
            end else begin
                oData_from_OM <= ram[iAddr_OM];
            end
`else
            oData_from_OM <= ram[iAddr_OM];
`endif
        end
    end

endmodule

// File: tb/tb_om_max_buffer.sv
// Self-checking bench for om_max_buffer: table-driven readback plus random frames vs a reference model.
module tb_om_max_buffer;
    localparam int N = 6561;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic        iFinish;
    logic        oInput_ready;
    logic [12:0] oPosition;
    logic [31:0] oMax_val;
    logic [12:0] iAddr_OM;
    logic [31:0] oData_from_OM;
    logic        iResult_done;

    om_max_buffer_if sif ();

    om_max_buffer #(.MAP_W(81), .MAP_N(N)) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iFinish       (iFinish),
        .score_if      (sif),
        .oInput_ready  (oInput_ready),
        .oPosition     (oPosition),
        .oMax_val      (oMax_val),
        .iAddr_OM      (iAddr_OM),
        .oData_from_OM (oData_from_OM),
        .iResult_done  (iResult_done)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [12:0] got_pos;
    logic [31:0] got_val;
    logic [31:0] frame [N];

    typedef struct {
        string       name;
        logic [12:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge iClk);
        #1;
        if (oInput_ready) begin
            pulses++;
            got_pos = oPosition;
            got_val = oMax_val;
        end
    endtask

    // Reference: largest score, earliest index among equals.
    task automatic model(output logic [12:0] pos, output logic [31:0] mx);
        logic [31:0] m[$];
        int idx[$];
        m   = frame.max();
        mx  = m[0];
        idx = frame.find_first_index(x) with (x == mx);
        pos = 13'(idx[0]);
    endtask

    task automatic send_frame(input int n, input int gap_pct, input int probe,
                              input logic [31:0] old_val);
        int i = 0;
        int cyc = 0;
        bit acc;
        bit probing;
        while (i < n) begin
            sif.score_valid = ($urandom_range(99) >= gap_pct);
            sif.score = sif.score_valid ? frame[i] : $urandom();
            iResult_done = ($urandom_range(15) == 0);
            acc = sif.score_valid && sif.score_ready;
            probing = acc && (i == probe);
            if (probing) iAddr_OM = 13'(probe);
            step();
            if (probing) check("rd_during_wr_old", oData_from_OM, old_val);
            if (acc) i++;
            cyc++;
            if (cyc > 30000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got %0d accepted want %0d", i, n);
                break;
            end
        end
        sif.score_valid = 1'b0;
        iResult_done = 1'b0;
    endtask

    task automatic frame_result(input string tag);
        logic [12:0] ep;
        logic [31:0] ev;
        model(ep, ev);
        step();
        step();
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_pos"}, 32'(got_pos), 32'(ep));
        check({tag, "_max"}, got_val, ev);
        check({tag, "_held_pos"}, 32'(oPosition), 32'(ep));
        check({tag, "_ready_low"}, 32'(sif.score_ready), 32'd0);
    endtask

    task automatic release_result(input string tag);
        iResult_done = 1'b1;
        step();
        iResult_done = 1'b0;
        check({tag, "_ready_back"}, 32'(sif.score_ready), 32'd1);
        pulses = 0;
    endtask

    initial begin
        logic [31:0] saved_val;
        logic [12:0] saved_pos;

        rd_tab[0] = '{name: "rd_0",    addr: 13'd0,    exp: 32'd0};
        rd_tab[1] = '{name: "rd_1",    addr: 13'd1,    exp: 32'd1};
        rd_tab[2] = '{name: "rd_262",  addr: 13'd262,  exp: 32'd262};
        rd_tab[3] = '{name: "rd_6560", addr: 13'd6560, exp: 32'd6560};
        rd_tab[4] = '{name: "rd_4000", addr: 13'd4000, exp: 32'd4000};

        iReset_n = 1'b0;
        iFinish = 1'b0;
        iResult_done = 1'b0;
        iAddr_OM = '0;
        sif.score_valid = 1'b0;
        sif.score = '0;
        step();
        step();
        check("rst_ready", 32'(sif.score_ready), 32'd1);
        check("rst_pulse", 32'(oInput_ready), 32'd0);
        check("rst_pos", 32'(oPosition), 32'd0);
        check("rst_max", oMax_val, 32'd0);
        check("rst_data", oData_from_OM, 32'd0);
        iReset_n = 1'b1;
        pulses = 0;

        // Ramp frame, maximum at the last address.
        for (int k = 0; k < N; k++) frame[k] = 32'(k);
        send_frame(N, 0, -1, 32'd0);
        frame_result("ramp");
        check("ramp_pos_const", 32'(got_pos), 32'd6560);

        for (int v = 0; v < 5; v++) begin
            iAddr_OM = rd_tab[v].addr;
            step();
            check(rd_tab[v].name, oData_from_OM, rd_tab[v].exp);
        end
`ifdef OM_ADDR_GUARD_EN
        iAddr_OM = 13'd6600;
        step();
        check("rd_guard_6600", oData_from_OM, 32'd0);
`endif
        release_result("ramp");

        // Tie frame: first of two equal maxima wins; probe read-during-write at 262.
        for (int k = 0; k < N; k++) frame[k] = 32'd5;
        frame[100] = 32'h4E66667;
        frame[200] = 32'h4E66667;
        send_frame(N, 0, 262, 32'd262);
        frame_result("tie");
        iAddr_OM = 13'd262;
        step();
        check("tie_rd_262", oData_from_OM, 32'd5);
        iAddr_OM = 13'd100;
        step();
        check("tie_rd_100", oData_from_OM, 32'h4E66667);

        // Scores offered while waiting must be refused.
        saved_val = oMax_val;
        sif.score_valid = 1'b1;
        sif.score = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) step();
        sif.score_valid = 1'b0;
        check("wait_max_held", oMax_val, saved_val);
        check("wait_ready_low", 32'(sif.score_ready), 32'd0);
        check("wait_no_pulse", 32'(pulses), 32'd1);
        release_result("tie");

        // Abort a partial frame.
        for (int k = 0; k < N; k++) frame[k] = 32'($urandom_range(50000));
        send_frame(3000, 0, -1, 32'd0);
        iFinish = 1'b1;
        step();
        iFinish = 1'b0;
        check("abort_ready", 32'(sif.score_ready), 32'd1);
        check("abort_max", oMax_val, 32'd0);
        check("abort_pos", 32'(oPosition), 32'd0);
        check("abort_data", oData_from_OM, 32'd0);
        for (int c = 0; c < 3; c++) step();
        check("abort_no_pulse", 32'(pulses), 32'd0);

        // Random frame, gapless then with 50% valid duty.
        send_frame(N, 0, -1, 32'd0);
        frame_result("rnd");
        saved_val = got_val;
        saved_pos = got_pos;
        release_result("rnd");
        send_frame(N, 50, -1, 32'd0);
        frame_result("gap");
        check("gap_same_max", got_val, saved_val);
        check("gap_same_pos", 32'(got_pos), 32'(saved_pos));

        // Reset while waiting abandons the result.
        iReset_n = 1'b0;
        step();
        iReset_n = 1'b1;
        check("rst_wait_ready", 32'(sif.score_ready), 32'd1);
        check("rst_wait_max", oMax_val, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
